// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit packetiser and CRC helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package usb_tx_pkg;

    // Packetiser sequencing states. Encodings 5..7 are unused and recover to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PID  = 3'd1,
        ST_DATA = 3'd2,
        ST_CRC1 = 3'd3,
        ST_CRC2 = 3'd4
    } state_e;

    // CRC-16/USB: polynomial 0x8005 processed LSB-first.
    localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
    localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

    // Data PIDs.
    localparam logic [3:0] DATA0 = 4'b0011;
    localparam logic [3:0] DATA1 = 4'b1011;

    // PID byte on the wire: check nibble (complement) in the upper half.
    function automatic logic [7:0] pid_byte(input logic [3:0] p);
        return {~p, p};
    endfunction

endpackage

// File: rtl/usb_crc16_byte.sv
// One-byte CRC-16/USB update: crc_out = crc_in advanced over data_in, LSB first.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
// Ports: crc_in  - current (non-inverted) CRC register
//        data_in - byte to fold in
//        crc_out - updated CRC register
module usb_crc16_byte
    import usb_tx_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);

    logic [15:0] crc_v;

    always_comb begin
        crc_v = crc_in ^ {8'h00, data_in};
        for (int i = 0; i < 8; i++) begin
            if (crc_v[0]) begin
                crc_v = (crc_v >> 1) ^ CRC16_POLY_REFL;
            end else begin
                crc_v = crc_v >> 1;
            end
        end
        crc_out = crc_v;
    end

endmodule

// File: rtl/usb_tx_packetizer.sv
// USB transmit packetiser: PID byte, len payload bytes from upstream, then two CRC16 bytes.
// Latency: first byte (PID) is valid one cycle after send_data is sampled in IDLE.
// Backpressure: tx_data/tx_valid hold while !tx_ready; data_ready only when the output slot frees.
// Ports: clk/reset (async, active-low); send_data/pid/len request a packet (sampled in IDLE);
//        abort kills the packet; data_in/data_valid/data_ready upstream bytes;
//        tx_data/tx_valid/tx_ready downstream bytes; busy = not IDLE; done = pulse after last CRC byte.
module usb_tx_packetizer
    import usb_tx_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              send_data,
    input  logic [3:0]        pid,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [15:0]       crc_q, crc_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;

    logic [15:0]       crc_upd;
    logic              slot_free;
    logic              tx_acc;
    logic              more_data;

    usb_crc16_byte u_crc (
        .crc_in  (crc_q),
        .data_in (data_in[7:0]),
        .crc_out (crc_upd)
    );

    // Output register is empty, or its byte is leaving this cycle.
    assign slot_free = !tx_valid_q || tx_ready;
    assign tx_acc    = tx_valid_q && tx_ready;
    // Stop pulling upstream once len_eff bytes have been loaded.
    assign more_data = (cnt_q != len_q);

    assign data_ready = (state_q == ST_DATA) && more_data && slot_free;

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        done_d     = 1'b0;
        crc_d      = crc_q;
        cnt_d      = cnt_q;
        len_d      = len_q;

        case (state_q)
            ST_IDLE: begin
                tx_valid_d = 1'b0;
                if (send_data) begin
                    len_d      = (len > MAX_LEN_C) ? MAX_LEN_C : len;
                    crc_d      = CRC16_INIT;
                    cnt_d      = '0;
                    tx_data_d  = DATA_W'(pid_byte(pid));
                    tx_valid_d = 1'b1;
                    state_d    = ST_PID;
                end
            end

            ST_PID: begin
                if (tx_acc) begin
                    if (len_q != '0) begin
                        // Payload loads from DATA once data_ready can be raised.
                        tx_valid_d = 1'b0;
                        state_d    = ST_DATA;
                    end else begin
                        tx_data_d = DATA_W'(~crc_q[7:0]);
                        state_d   = ST_CRC1;
                    end
                end
            end

            ST_DATA: begin
                if (slot_free) begin
                    if (!more_data) begin
                        // Last payload byte is being accepted; crc_q already covers it.
                        tx_data_d  = DATA_W'(~crc_q[7:0]);
                        tx_valid_d = 1'b1;
                        state_d    = ST_CRC1;
                    end else if (data_valid) begin
                        tx_data_d  = data_in;
                        tx_valid_d = 1'b1;
                        crc_d      = crc_upd;
                        cnt_d      = cnt_q + LEN_W'(1);
                    end else begin
                        // Upstream underrun: bubble on the tx bus, keep waiting.
                        tx_valid_d = 1'b0;
                    end
                end
            end

            ST_CRC1: begin
                if (tx_acc) begin
                    tx_data_d = DATA_W'(~crc_q[15:8]);
                    state_d   = ST_CRC2;
                end
            end

            ST_CRC2: begin
                if (tx_acc) begin
                    tx_valid_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end
            end

            default: begin
                tx_valid_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase

        // Abort wins over any accept in flight; the pending byte is discarded.
        if (abort && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            tx_valid_d = 1'b0;
            done_d     = 1'b0;
            crc_d      = crc_q;
            cnt_d      = cnt_q;
        end
    end

    assign busy_d = (state_d != ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            crc_q      <= CRC16_INIT;
            cnt_q      <= '0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            crc_q      <= crc_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_usb_tx_packetizer.sv
// Bench for usb_tx_packetizer: packet-level model of PID/payload/CRC bytes checked every cycle.
// Latency: n/a (testbench).
// Backpressure: tx_ready driven constant, toggling or held per test.
module tb_usb_tx_packetizer;
    import usb_tx_pkg::*;

    localparam int MAX_LEN = 64;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             send_data = 1'b0;
    logic [3:0]       pid = '0;
    logic [LEN_W-1:0] len = '0;
    logic             abort = 1'b0;
    logic [7:0]       data_in = '0;
    logic             data_valid = 1'b0;
    logic             data_ready;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready = 1'b1;
    logic             busy;
    logic             done;

    usb_tx_packetizer #(.DATA_W(8), .MAX_LEN(MAX_LEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .send_data  (send_data),
        .pid        (pid),
        .len        (len),
        .abort      (abort),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference CRC-16/USB, one message bit at a time (reflected register, LSB first).
    function automatic logic [15:0] crc_ref(input logic [7:0] b[$]);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (b[k]) begin
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ b[k][j];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        end
        return c;
    endfunction

    logic [7:0] exp_q[$];
    logic [7:0] src_q[$];
    logic [7:0] got_q[$];

    // Monitor state
    logic       prev_hold = 1'b0;
    logic [7:0] prev_dat = '0;
    logic       done_pend = 1'b0;
    logic       up_hs = 1'b0;
    logic [7:0] exp_b;
    int         acc_cnt = 0;
    int         done_cnt = 0;
    int         busy_cnt = 0;
    int         idle_cnt = 0;

    // Driver state
    int         rdy_mode = 0;     // 0: ready=1, 1: toggle, 2: manual
    int         stall_after = -1;
    int         stall = 0;
    int         popped = 0;
    logic [7:0] drop_b;

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            prev_hold = 1'b0;
            done_pend = 1'b0;
            up_hs     = 1'b0;
        end else begin
            check("done", done, done_pend);
            done_pend = 1'b0;
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            if (busy && !tx_valid) idle_cnt++;
            if (prev_hold) begin
                check("hold_vld", tx_valid, 1'b1);
                check("hold_dat", tx_data, prev_dat);
            end
            up_hs = data_valid && data_ready;
            if (abort && busy) begin
                exp_q.delete();
                prev_hold = 1'b0;
            end else begin
                prev_hold = tx_valid && !tx_ready;
                prev_dat  = tx_data;
                if (tx_valid && tx_ready) begin
                    acc_cnt++;
                    got_q.push_back(tx_data);
                    if (exp_q.size() == 0) begin
                        check("extra_byte", 32'(exp_q.size()), 1);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("tx_byte", tx_data, exp_b);
                        if (exp_q.size() == 0) done_pend = 1'b1;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (up_hs && src_q.size() > 0) begin
            drop_b = src_q.pop_front();
            popped++;
            if (popped == stall_after) stall = 3;
        end else if (stall > 0) begin
            stall--;
        end
        data_valid = (src_q.size() > 0) && (stall == 0);
        data_in    = (src_q.size() > 0) ? src_q[0] : 8'h00;
        if (rdy_mode == 0) tx_ready = 1'b1;
        else if (rdy_mode == 1) tx_ready = ~tx_ready;
    end

    task automatic send(input logic [3:0] p, input int n_req, input logic [7:0] payload[$]);
        logic [7:0]  pl[$];
        logic [15:0] c;
        int          n;
        n = (n_req > MAX_LEN) ? MAX_LEN : n_req;
        for (int i = 0; i < n; i++) pl.push_back(payload[i]);
        c = crc_ref(pl) ^ 16'hFFFF;
        exp_q.push_back({~p, p});
        foreach (pl[i]) exp_q.push_back(pl[i]);
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
        src_q  = payload;
        popped = 0;
        got_q.delete();
        busy_cnt = 0;
        idle_cnt = 0;
        @(posedge clk); #2;
        pid       = p;
        len       = LEN_W'(n_req);
        send_data = 1'b1;
        @(posedge clk); #2;
        send_data = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int start;
        int k;
        start = done_cnt;
        k = 0;
        while (done_cnt == start && k < budget) begin
            @(posedge clk);
            k++;
        end
        check(name, 32'(done_cnt - start), 1);
        check("exp_empty", 32'(exp_q.size()), 0);
    endtask

    task automatic wait_acc(input int target, input int budget);
        int k;
        k = 0;
        while (acc_cnt < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        check("acc_reach", 32'(acc_cnt), 32'(target));
    endtask

    logic [7:0] pl[$];
    logic [7:0] t2[$];
    int         a0;
    int         d0;

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #2;
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_data_ready", data_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        reset = 1'b1;

        // Model pins
        pl.delete();
        for (int i = 0; i < 9; i++) pl.push_back(8'(8'h31 + i));
        check("model_crc_check", crc_ref(pl) ^ 16'hFFFF, 16'hB4C8);
        pl.delete();
        check("model_crc_zlp", crc_ref(pl) ^ 16'hFFFF, 16'h0000);

        // Zero-length DATA0
        send(DATA0, 0, pl);
        wait_done("zlp_done", 40);
        check("zlp_busy_cycles", 32'(busy_cnt), 3);
        check("zlp_nbytes", 32'(got_q.size()), 3);
        check("zlp_b0", got_q[0], 8'hC3);
        check("zlp_b1", got_q[1], 8'h00);
        check("zlp_b2", got_q[2], 8'h00);

        // DATA1 "123456789", ready always high
        for (int i = 0; i < 9; i++) pl.push_back(8'(8'h31 + i));
        send(DATA1, 9, pl);
        wait_done("d9_done", 60);
        check("d9_nbytes", 32'(got_q.size()), 12);
        check("d9_pid", got_q[0], 8'h4B);
        check("d9_b1", got_q[1], 8'h31);
        check("d9_crc_lo", got_q[10], 8'hC8);
        check("d9_crc_hi", got_q[11], 8'hB4);
        check("d9_idle", 32'(idle_cnt), 1);
        t2 = got_q;

        // Same packet, ready toggling
        rdy_mode = 1;
        send(DATA1, 9, pl);
        wait_done("tog_done", 100);
        check("tog_nbytes", 32'(got_q.size()), 12);
        for (int i = 0; i < 12 && i < got_q.size(); i++) check("tog_same", got_q[i], t2[i]);
        rdy_mode = 0;

        // Upstream stall of 3 cycles after the second payload byte
        pl.delete();
        for (int i = 0; i < 4; i++) pl.push_back(8'(8'hA0 + i));
        stall_after = 2;
        send(DATA0, 4, pl);
        wait_done("stall_done", 60);
        check("stall_idle", 32'(idle_cnt), 4);
        check("stall_nbytes", 32'(got_q.size()), 7);
        stall_after = -1;

        // Abort in DATA after two payload bytes
        pl.delete();
        for (int i = 0; i < 4; i++) pl.push_back(8'(8'h10 + i));
        a0 = acc_cnt;
        d0 = done_cnt;
        send(DATA1, 4, pl);
        wait_acc(a0 + 3, 50);
        #2;
        abort = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0;
        check("abort_tx_valid", tx_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        src_q.delete();
        repeat (3) @(posedge clk);
        check("abort_no_done", 32'(done_cnt), 32'(d0));
        check("abort_nbytes", 32'(got_q.size()), 3);
        pl.delete();
        send(DATA0, 0, pl);
        wait_done("post_abort_done", 40);
        check("post_abort_nbytes", 32'(got_q.size()), 3);
        check("post_abort_b1", got_q[1], 8'h00);
        check("post_abort_b2", got_q[2], 8'h00);

        // Async reset while the first CRC byte is held
        pl.delete();
        pl.push_back(8'h55);
        pl.push_back(8'hAA);
        a0 = acc_cnt;
        send(DATA0, 2, pl);
        wait_acc(a0 + 3, 50);
        #2;
        rdy_mode = 2;
        tx_ready = 1'b0;
        @(negedge clk); #2;
        check("pre_rst_valid", tx_valid, 1'b1);
        reset = 1'b0;
        #1;
        check("arst_tx_valid", tx_valid, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_tx_data", tx_data, 8'h00);
        src_q.delete();
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;

        // Over-length request is clipped to MAX_LEN
        pl.delete();
        for (int i = 0; i < MAX_LEN + 5; i++) pl.push_back(8'(i * 7 + 3));
        send(DATA1, MAX_LEN + 5, pl);
        wait_done("clip_done", 400);
        check("clip_nbytes", 32'(got_q.size()), 32'(MAX_LEN + 3));
        check("clip_left", 32'(src_q.size()), 5);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_tx_packetizer.md
Name: usb_tx_packetizer

Overview:
Parametrised USB transmit packetiser, successor to the fixed IDLE/CRC1/CRC2 test sequencer. On a send request it emits a PID byte, then LEN payload bytes pulled from an upstream source, then the two CRC16 bytes. All bytes go out over a tx_valid/tx_ready byte handshake toward the UTMI-side transmitter. Adds payload length, CRC16 computation, zero-length packets, abort, and busy/done status.

Parameters:
DATA_W, 8, byte width of payload and tx bus; only 8 is supported, and the parameter exists for width checks.
MAX_LEN, 64, maximum payload bytes per packet.
LEN_W, $clog2(MAX_LEN+1), width of len and the byte counter.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
send_data  in  1  start request; sampled only in IDLE
pid  in  4  packet ID; sampled with send_data
len  in  LEN_W  payload byte count; sampled with send_data
abort  in  1  terminate the current packet
data_in  in  DATA_W  payload byte from upstream
data_valid  in  1  data_in valid
data_ready  out  1  upstream byte accepted this cycle when data_valid && data_ready
tx_data  out  DATA_W  byte to transmitter
tx_valid  out  1  tx_data valid
tx_ready  in  1  transmitter accepts the byte when tx_valid && tx_ready
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after the last CRC byte is accepted

Behaviour:
- Reset is asynchronous, active-low: reset=0 forces state=IDLE, tx_valid=0, tx_data=0, data_ready=0, busy=0, done=0, CRC=16'hFFFF, counter=0.
- All outputs are registered except data_ready, which is combinational from state, tx_valid and tx_ready.
- States: IDLE, PID, DATA, CRC1, CRC2. The encoding lives in the package.
- IDLE:
  - send_data=1 latches pid and len_eff = min(len, MAX_LEN), and sets CRC to FFFF.
  - Next cycle enters PID with tx_data={~pid,pid} and tx_valid=1, so there is one cycle of latency from request to first byte.
- Handshake rule: tx_data and tx_valid are held stable while tx_valid && !tx_ready. A new byte loads only when the output register is empty or is being accepted this cycle.
- PID, on accept:
  - if len_eff>0, go to DATA;
  - otherwise go to CRC1 with tx_data = ~CRC[7:0].
- DATA:
  - data_ready = !tx_valid || tx_ready.
  - On upstream handshake: load tx_data=data_in, set tx_valid=1, update CRC, increment counter.
  - Upstream stall: if data_valid=0 when the slot is free, tx_valid drops to 0. There is no underrun error, and the state holds.
  - After the len_eff-th byte is accepted downstream, go to CRC1 with tx_data = ~CRC[7:0] (post-update CRC).
- CRC1: on accept, go to CRC2 with tx_data = ~CRC[15:8].
- CRC2: on accept, go to IDLE, set tx_valid=0, pulse done=1 for one cycle.
- CRC is CRC-16/USB:
  - polynomial 0x8005, reflected (LSB-first, 0xA001 form);
  - init FFFF, output inverted;
  - transmitted low byte first.
  - Update is one byte per cycle, combinational into the CRC register.
- Zero-length packet: PID, then 8'h00, 8'h00 (inverted FFFF).
- abort=1 in any non-IDLE state:
  - next cycle enters IDLE with tx_valid=0 and no done pulse;
  - an in-flight byte is dropped;
  - abort has priority over a simultaneous tx_ready accept.
  - In IDLE, abort is ignored; abort together with send_data in IDLE still starts a packet.
- send_data outside IDLE is ignored and not queued.
- Counter never wraps: LEN_W holds MAX_LEN. len > MAX_LEN is clipped, with no error flag.
- Reset asserted mid-packet: immediate return to reset values; no partial CRC is emitted.
- Unused state encodings go to IDLE with tx_valid=0.

Decomposition:
- Package usb_tx_pkg holds:
  - state enum typedef;
  - CRC16_POLY_REFL=16'hA001, CRC16_INIT=16'hFFFF;
  - PID constants DATA0=4'b0011, DATA1=4'b1011.
- Sub-module usb_crc16_byte: purely combinational, crc_next = f(crc, byte). It is shared later by the receive checker.

Test Plan:
- pid=DATA0, len=0, tx_ready=1 constant -> tx bytes C3, 00, 00; done pulses on the cycle after the last accept; busy high for 3 cycles.
- pid=DATA1, len=9, data "123456789" (31..39), tx_ready=1 -> bytes 4B, 31..39, C8, B4 (CRC check 0xB4C8).
- Same packet with tx_ready toggling 1-0-1-0 -> identical byte sequence; tx_data stable whenever tx_valid=1 && tx_ready=0.
- len=4 with data_valid low for 3 cycles after byte 2 -> tx_valid=0 during the stall; resumes with byte 3; CRC matches the reference model.
- abort asserted in DATA after byte 2 -> IDLE next cycle, tx_valid=0, no done. A following len=0 packet gives C3, 00, 00 (CRC reinitialised).
- reset driven low asynchronously mid-CRC1 -> tx_valid and busy go 0 without a clock edge; len=MAX_LEN+5 afterwards sends exactly MAX_LEN payload bytes.
